writeback_sequencer: RTL and testbench

Write-port initiator for the 32×32 register file. It buffers results from two producers, the ALU stage and the memory/load stage, in small per-source FIFOs. It arbitrates round-robin between them and drives exactly one registered write per cycle onto the register file's `regWrite`/`writeReg`/`writeData` inputs. It sits between the execute/memory stages and the register file, and removes write-port conflicts when both stages retire in the same cycle.

---
 rtl/writeback_sequencer.sv | 102 ++++++++++
 tb/tb_writeback_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_sequencer.sv
// Round-robin write-port sequencer: per-source FIFOs for ALU and load results feeding one
// registered register-file write per cycle. Optional feature macro: WB_ZERO_DROP_EN.
module writeback_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Handshake: an entry transfers on a rising edge when valid && ready. Ready depends only
    // on the registered count, never on valid or on a pop in the same cycle.
    logic [36:0]   store [2][DEPTH];
    logic [PW-1:0] head  [2];
    logic [PW-1:0] tail  [2];
    logic [CW-1:0] count [2];
    logic [36:0]   inEntry [2];
    logic [1:0]    inValid;
    logic [1:0]    ready;
    logic [1:0]    keep;
    logic [1:0]    nonEmpty;
    logic [1:0]    pop;
    logic          grantAlu;
    logic          grantMem;
    logic          favorAlu;

    always_comb begin
        inValid    = {mem_valid, alu_valid};
        inEntry[0] = {alu_reg, alu_data};
        inEntry[1] = {mem_reg, mem_data};
        for (int s = 0; s < 2; s++) begin
            nonEmpty[s] = (count[s] != '0);
            ready[s]    = (count[s] < FULL);
`ifdef WB_ZERO_DROP_EN
            // Register-0 entries complete the handshake but are never stored.
            keep[s] = inValid[s] && ready[s] && (inEntry[s][36:32] != 5'd0);
`else
            keep[s] = inValid[s] && ready[s];
`endif
        end
    end

    // Entries pushed this cycle are invisible to the arbiter until the next one.
    assign grantAlu  = nonEmpty[0] && (!nonEmpty[1] || favorAlu);
    assign grantMem  = nonEmpty[1] && !grantAlu;
    assign pop       = {grantMem, grantAlu};
    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign idle      = (count[0] == '0) && (count[1] == '0) && !regWrite;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            favorAlu  <= 1'b1;
            regWrite  <= 1'b0;
            writeReg  <= 5'd0;
            writeData <= 32'd0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (keep[s]) begin
                    store[s][tail[s]] <= inEntry[s];
                    tail[s]           <= tail[s] + 1'b1;
                end
                if (pop[s]) begin
                    head[s] <= head[s] + 1'b1;
                end
                case ({keep[s], pop[s]})
                    2'b10:   count[s] <= count[s] + 1'b1;
                    2'b01:   count[s] <= count[s] - 1'b1;
                    default: count[s] <= count[s];
                endcase
            end
            regWrite <= grantAlu || grantMem;
            // The round-robin pointer only moves on a grant; address/data hold otherwise.
            if (grantAlu) begin
                {writeReg, writeData} <= store[0][head[0]];
                favorAlu              <= 1'b0;
            end else if (grantMem) begin
                {writeReg, writeData} <= store[1][head[1]];
                favorAlu              <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-level reference model.
module tb_writeback_sequencer;
  localparam int DEPTH = 4;
`ifdef WB_ZERO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        idle;

  writeback_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .idle(idle)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  logic [36:0] alu_q[$];
  logic [36:0] mem_q[$];
  logic [36:0] exp_q[$];
  logic [36:0] write_log[$];
  logic        m_favor_alu;
  logic        exp_rw;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_rw;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_alu_rdy;
    logic        e_mem_rdy;
    logic        e_idle;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  function automatic bit stored(input logic [4:0] r);
    return !(DROP && r == 5'd0);
  endfunction

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    alu_q.delete();
    mem_q.delete();
    m_favor_alu = 1'b1;
    exp_rw = 1'b0;
    exp_reg = 5'd0;
    exp_data = 32'd0;
    check("rst_regWrite", regWrite, 1'b0);
    check("rst_writeReg", writeReg, 5'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
  endtask

  // One cycle against the queue-level model: check pre-edge outputs, predict, clock, check.
  task automatic model_cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                             input logic mv, input logic [4:0] mr, input logic [31:0] md,
                             output logic acc_a, output logic acc_m);
    logic [36:0] e;
    drive(av, ar, ad, mv, mr, md);
    #0;
    check("alu_ready", alu_ready, alu_q.size() < DEPTH);
    check("mem_ready", mem_ready, mem_q.size() < DEPTH);
    check("idle", idle, alu_q.size() == 0 && mem_q.size() == 0 && !exp_rw);
    acc_a = av && (alu_q.size() < DEPTH);
    acc_m = mv && (mem_q.size() < DEPTH);
    exp_rw = 1'b0;
    if (alu_q.size() > 0 && (mem_q.size() == 0 || m_favor_alu)) begin
      e = alu_q.pop_front();
      {exp_reg, exp_data} = e;
      exp_rw = 1'b1;
      m_favor_alu = 1'b0;
    end else if (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      {exp_reg, exp_data} = e;
      exp_rw = 1'b1;
      m_favor_alu = 1'b1;
    end
    if (acc_a && stored(ar)) alu_q.push_back({ar, ad});
    if (acc_m && stored(mr)) mem_q.push_back({mr, md});
    step();
    check("regWrite", regWrite, exp_rw);
    check("writeReg", writeReg, exp_reg);
    check("writeData", writeData, exp_data);
    if (regWrite === 1'b1) write_log.push_back({writeReg, writeData});
  endtask

  initial begin
    logic acc_a, acc_m;
    int a_idx, m_idx, first_w, last_w, n_w;
    logic saw_full, saw_recover, prev_rdy;
    logic [36:0] got;
    logic [4:0]  r4_reg, r5_reg, r78_reg, r8_reg;
    logic [31:0] r4_data, r5_data, r78_data, r8_data;

    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    // ---- directed vector table ----
    r4_reg  = DROP ? 5'd5 : 5'd0;
    r4_data = DROP ? 32'h12345678 : 32'hDEADBEEF;
    r5_reg  = r4_reg;
    r5_data = r4_data;
    r78_reg  = DROP ? 5'd8 : 5'd7;
    r78_data = DROP ? 32'hB8B8B8B8 : 32'hA7A7A7A7;
    r8_reg   = DROP ? 5'd7 : 5'd8;
    r8_data  = DROP ? 32'hA7A7A7A7 : 32'hB8B8B8B8;
    vecs[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b1, 5'd5, 32'h12345678, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd5, 32'h12345678, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF,
                1'b0, 5'd5, 32'h12345678, 1'b1, 1'b1, DROP};
    vecs[4] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                !DROP, r4_reg, r4_data, 1'b1, 1'b1, DROP};
    vecs[5] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b0, r5_reg, r5_data, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 5'd7, 32'hA7A7A7A7, 1'b1, 5'd8, 32'hB8B8B8B8,
                1'b0, r5_reg, r5_data, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b1, r78_reg, r78_data, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b1, r8_reg, r8_data, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                1'b0, r8_reg, r8_data, 1'b1, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      step();
      check($sformatf("vec%0d_regWrite", i), regWrite, vecs[i].e_rw);
      check($sformatf("vec%0d_writeReg", i), writeReg, vecs[i].e_reg);
      check($sformatf("vec%0d_writeData", i), writeData, vecs[i].e_data);
      check($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_alu_rdy);
      check($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].e_mem_rdy);
      check($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
    end

    // ---- both sources streaming: strict alternation starting with ALU ----
    do_reset();
    exp_q.delete();
    write_log.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({5'(i + 1), 32'hA000_0000 + 32'(i)});
      exp_q.push_back({5'(i + 9), 32'hB000_0000 + 32'(i)});
    end
    a_idx = 0; m_idx = 0; first_w = -1; last_w = -1; n_w = 0;
    for (int c = 0; c < 40; c++) begin
      model_cycle(a_idx < 8, 5'(a_idx + 1), 32'hA000_0000 + 32'(a_idx),
                  m_idx < 8, 5'(m_idx + 9), 32'hB000_0000 + 32'(m_idx), acc_a, acc_m);
      if (acc_a) a_idx++;
      if (acc_m) m_idx++;
      if (regWrite === 1'b1) begin
        if (first_w < 0) first_w = c;
        last_w = c;
        n_w++;
      end
    end
    check("stream_writes", n_w, 16);
    check("stream_span", last_w - first_w + 1, 16);
    check("stream_log_size", write_log.size(), exp_q.size());
    while (exp_q.size() > 0 && write_log.size() > 0) begin
      got = write_log.pop_front();
      check("stream_order", got, exp_q.pop_front());
    end

    // ---- load FIFO back-pressure with the ALU kept busy ----
    do_reset();
    saw_full = 1'b0; saw_recover = 1'b0; prev_rdy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (prev_rdy == 1'b0 && mem_ready === 1'b1) saw_recover = 1'b1;
      if (mem_ready === 1'b0) saw_full = 1'b1;
      prev_rdy = mem_ready;
      model_cycle(1'b1, 5'(c % 31 + 1), 32'hC000_0000 + 32'(c),
                  1'b1, 5'(c % 31 + 1), 32'hD000_0000 + 32'(c), acc_a, acc_m);
    end
    check("mem_full_seen", saw_full, 1'b1);
    check("mem_ready_recovered", saw_recover, 1'b1);
    for (int c = 0; c < 12; c++) model_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_m);
    check("bp_drained_alu", alu_q.size(), 0);
    check("bp_drained_mem", mem_q.size(), 0);

    // ---- reset mid-operation discards queued entries ----
    do_reset();
    for (int c = 0; c < 5; c++) begin
      model_cycle(1'b1, 5'(c + 20), 32'hE000_0000 + 32'(c),
                  1'b1, 5'(c + 25), 32'hF000_0000 + 32'(c), acc_a, acc_m);
    end
    check("pre_reset_alu_count", alu_q.size(), 3);
    check("pre_reset_mem_count", mem_q.size(), 3);
    do_reset();
    for (int c = 0; c < 12; c++) model_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_m);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int pct;
      pct = (c < 200) ? 30 : (c < 400) ? 90 : 60;
      model_cycle($urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom,
                  acc_a, acc_m);
    end
    for (int c = 0; c < 12; c++) model_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_m);
    check("rand_drained_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
